// File: rtl/usb_controller.sv
// USB-to-SD bridge transaction sequencer: address OUT transaction, then an OUT (SD write)
// or IN (SD read) transaction, driving the SD block and USB transmitter through level handshakes.
module usb_controller #(
  parameter logic [3:0] PID_OUT = 4'b0001,
  parameter logic [3:0] PID_IN  = 4'b1001
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       pid_rdy,
  input  logic [3:0] rx_pid,
  input  logic [1:0] rx_packet_done,
  input  logic       sd_done,
  input  logic       sd_err,
  input  logic       tx_done,
  input  logic       tx_err,
  output logic       sd_addr_rdy,
  output logic       sd_write,
  output logic       sd_read,
  output logic       tx_transmit,
  output logic       tx_send_good,
  output logic       tx_send_bad
);

  typedef enum logic [3:0] {
    IDLE,
    TOK1,
    TOK1_REL,
    ADDR_WAIT,
    ADDR_REL,
    ADDR_RDY,
    IDLE2,
    TOK2,
    TOK2_REL,
    DATA_WAIT,
    SELECT_RW,
    WRITE,
    READ,
    ACK,
    SEND_DATA,
    NAK
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   dir;       // 0: write, 1: read
  logic   dir_nxt;

  logic pkt_idle;
  logic pkt_ok;
  logic pkt_err;

  assign pkt_idle = (rx_packet_done == 2'b00);
  assign pkt_ok   = (rx_packet_done == 2'b01);
  assign pkt_err  = rx_packet_done[1];

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state <= IDLE;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    dir_nxt      = dir;
    sd_addr_rdy  = 1'b0;
    sd_write     = 1'b0;
    sd_read      = 1'b0;
    tx_transmit  = 1'b0;
    tx_send_good = 1'b0;
    tx_send_bad  = 1'b0;

    case (state)
      IDLE: begin
        if (pid_rdy && rx_pid == PID_OUT) state_nxt = TOK1;
      end
      // Release states make a multi-cycle done level count as a single packet.
      TOK1: begin
        if (pkt_err)     state_nxt = IDLE;
        else if (pkt_ok) state_nxt = TOK1_REL;
      end
      TOK1_REL: begin
        if (pkt_err)       state_nxt = IDLE;
        else if (pkt_idle) state_nxt = ADDR_WAIT;
      end
      ADDR_WAIT: begin
        if (pkt_err)     state_nxt = IDLE;
        else if (pkt_ok) state_nxt = ADDR_REL;
      end
      ADDR_REL: begin
        if (pkt_err)       state_nxt = IDLE;
        else if (pkt_idle) state_nxt = ADDR_RDY;
      end
      ADDR_RDY: begin
        sd_addr_rdy = 1'b1;
        state_nxt   = IDLE2;
      end
      IDLE2: begin
        if (pid_rdy && rx_pid == PID_OUT) begin
          dir_nxt   = 1'b0;
          state_nxt = TOK2;
        end else if (pid_rdy && rx_pid == PID_IN) begin
          dir_nxt   = 1'b1;
          state_nxt = TOK2;
        end
      end
      TOK2: begin
        if (pkt_err)     state_nxt = IDLE;
        else if (pkt_ok) state_nxt = TOK2_REL;
      end
      TOK2_REL: begin
        if (pkt_err)       state_nxt = IDLE;
        else if (pkt_idle) state_nxt = DATA_WAIT;
      end
      // No release wait here: the done level may linger while the SD block works.
      DATA_WAIT: begin
        if (pkt_err)     state_nxt = IDLE;
        else if (pkt_ok) state_nxt = SELECT_RW;
      end
      SELECT_RW: begin
        state_nxt = dir ? READ : WRITE;
      end
      WRITE: begin
        sd_write = 1'b1;
        if (sd_err)       state_nxt = NAK;
        else if (sd_done) state_nxt = ACK;
      end
      READ: begin
        sd_read = 1'b1;
        if (sd_err)       state_nxt = NAK;
        else if (sd_done) state_nxt = SEND_DATA;
      end
      ACK: begin
        tx_transmit  = 1'b1;
        tx_send_good = 1'b1;
        if (tx_done || tx_err) state_nxt = IDLE;
      end
      SEND_DATA: begin
        tx_transmit = 1'b1;
        if (tx_done || tx_err) state_nxt = IDLE;
      end
      NAK: begin
        tx_transmit = 1'b1;
        tx_send_bad = 1'b1;
        if (tx_done || tx_err) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_controller.sv
// Directed bench for usb_controller: write, read, multi-cycle done, SD error, packet error, reset.
module tb_usb_controller;

  logic       clk;
  logic       n_rst;
  logic       pid_rdy;
  logic [3:0] rx_pid;
  logic [1:0] rx_packet_done;
  logic       sd_done;
  logic       sd_err;
  logic       tx_done;
  logic       tx_err;
  logic       sd_addr_rdy;
  logic       sd_write;
  logic       sd_read;
  logic       tx_transmit;
  logic       tx_send_good;
  logic       tx_send_bad;

  int n_chk;
  int n_fail;

  // Output vector order: {sd_addr_rdy, sd_write, sd_read, tx_transmit, tx_send_good, tx_send_bad}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_ADDR = 6'b100000;
  localparam logic [5:0] O_WR   = 6'b010000;
  localparam logic [5:0] O_RD   = 6'b001000;
  localparam logic [5:0] O_ACK  = 6'b000110;
  localparam logic [5:0] O_SEND = 6'b000100;
  localparam logic [5:0] O_NAK  = 6'b000101;

  usb_controller dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .pid_rdy        (pid_rdy),
    .rx_pid         (rx_pid),
    .rx_packet_done (rx_packet_done),
    .sd_done        (sd_done),
    .sd_err         (sd_err),
    .tx_done        (tx_done),
    .tx_err         (tx_err),
    .sd_addr_rdy    (sd_addr_rdy),
    .sd_write       (sd_write),
    .sd_read        (sd_read),
    .tx_transmit    (tx_transmit),
    .tx_send_good   (tx_send_good),
    .tx_send_bad    (tx_send_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {sd_addr_rdy, sd_write, sd_read, tx_transmit, tx_send_good, tx_send_bad};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // OUT token + address packet from IDLE, ending in IDLE2 after the address strobe.
  task automatic addr_phase(input string tag);
    pid_rdy = 1'b1; rx_pid = 4'b0001; cyc(); pid_rdy = 1'b0;
    rx_packet_done = 2'b01; cyc();
    rx_packet_done = 2'b00; cyc();
    rx_packet_done = 2'b01; cyc();
    chk({tag, "_pre_addr"}, O_NONE);
    rx_packet_done = 2'b00; cyc();
    chk({tag, "_addr_pulse"}, O_ADDR);
    cyc();
    chk({tag, "_addr_drop"}, O_NONE);
  endtask

  // Second token (given pid) + data packet, ending in SELECT_RW with done held at 01.
  task automatic data_phase(input logic [3:0] pid);
    pid_rdy = 1'b1; rx_pid = pid; cyc(); pid_rdy = 1'b0;
    rx_packet_done = 2'b01; cyc();
    rx_packet_done = 2'b00; cyc();
    rx_packet_done = 2'b01; cyc();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    n_rst = 1'b1;
    pid_rdy = 1'b0;
    rx_pid = 4'b0000;
    rx_packet_done = 2'b00;
    sd_done = 1'b0;
    sd_err = 1'b0;
    tx_done = 1'b0;
    tx_err = 1'b0;
    cyc();
    cyc();
    chk("reset", O_NONE);
    n_rst = 1'b0;
    cyc();
    chk("idle_after_reset", O_NONE);

    // Write flow
    addr_phase("wr");
    data_phase(4'b0001);
    chk("wr_select", O_NONE);
    rx_packet_done = 2'b00; cyc();
    chk("wr_write", O_WR);
    cyc();
    chk("wr_write_hold", O_WR);
    sd_done = 1'b1; cyc(); sd_done = 1'b0;
    chk("wr_ack", O_ACK);
    cyc();
    chk("wr_ack_hold", O_ACK);
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
    chk("wr_idle", O_NONE);

    // Read flow with the data done level held for 40 cycles
    addr_phase("rd");
    data_phase(4'b1001);
    chk("rd_select", O_NONE);
    cyc();
    chk("rd_read", O_RD);
    for (int i = 0; i < 38; i++) cyc();
    chk("rd_read_held_done", O_RD);
    sd_done = 1'b1; cyc();
    chk("rd_send_data", O_SEND);
    tx_done = 1'b1; cyc();
    chk("rd_idle", O_NONE);
    cyc();
    chk("rd_idle_inputs_high", O_NONE);
    sd_done = 1'b0; tx_done = 1'b0; rx_packet_done = 2'b00;

    // Multi-cycle done levels, then SD error with sd_done also set
    pid_rdy = 1'b1; rx_pid = 4'b0001; cyc(); pid_rdy = 1'b0;
    rx_packet_done = 2'b01; cyc(); cyc();
    rx_packet_done = 2'b00; cyc();
    rx_packet_done = 2'b01; cyc(); cyc();
    chk("mc_no_early_addr", O_NONE);
    rx_packet_done = 2'b00; cyc();
    chk("mc_addr_pulse", O_ADDR);
    cyc();
    chk("mc_addr_once", O_NONE);
    cyc();
    chk("mc_addr_still_low", O_NONE);
    pid_rdy = 1'b1; rx_pid = 4'b0001; cyc(); pid_rdy = 1'b0;
    rx_packet_done = 2'b01; cyc(); cyc();
    rx_packet_done = 2'b00; cyc();
    rx_packet_done = 2'b01; cyc();
    cyc();
    chk("mc_write", O_WR);
    sd_err = 1'b1; sd_done = 1'b1; cyc(); sd_err = 1'b0; sd_done = 1'b0;
    chk("err_nak", O_NAK);
    tx_err = 1'b1; cyc(); tx_err = 1'b0;
    chk("err_idle", O_NONE);
    rx_packet_done = 2'b00;

    // Packet error in ADDR_WAIT: a later 01/00 pair must not produce an address strobe
    pid_rdy = 1'b1; rx_pid = 4'b0001; cyc(); pid_rdy = 1'b0;
    rx_packet_done = 2'b01; cyc();
    rx_packet_done = 2'b00; cyc();
    rx_packet_done = 2'b10; cyc();
    rx_packet_done = 2'b01; cyc();
    rx_packet_done = 2'b00; cyc();
    chk("perr_no_addr", O_NONE);
    cyc();
    chk("perr_no_addr_late", O_NONE);

    // IN token in IDLE is ignored: the full address sequence must stay silent
    pid_rdy = 1'b1; rx_pid = 4'b1001; cyc(); pid_rdy = 1'b0;
    rx_packet_done = 2'b01; cyc();
    rx_packet_done = 2'b00; cyc();
    rx_packet_done = 2'b01; cyc();
    rx_packet_done = 2'b00; cyc();
    chk("wrong_pid_no_addr", O_NONE);
    cyc();
    chk("wrong_pid_no_addr_late", O_NONE);

    // Reset during WRITE drops sd_write without a clock edge
    addr_phase("rst");
    data_phase(4'b0001);
    rx_packet_done = 2'b00; cyc();
    chk("rst_write", O_WR);
    #2 n_rst = 1'b1;
    #1 chk("rst_async_drop", O_NONE);
    cyc();
    n_rst = 1'b0;
    pid_rdy = 1'b1; rx_pid = 4'b1001; cyc(); pid_rdy = 1'b0;
    rx_packet_done = 2'b01; cyc();
    rx_packet_done = 2'b00; cyc();
    rx_packet_done = 2'b01; cyc();
    rx_packet_done = 2'b00; cyc();
    chk("rst_needs_out_token", O_NONE);
    cyc();
    chk("rst_no_strobe", O_NONE);
    addr_phase("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
